// File: rtl/joy_serial_multi.sv
// joy_serial_multi: scans a daisy-chained parallel-in/serial-out joystick chain.
// Drives joy_load/joy_clk at CLK_DIV-cycle ticks, samples joy_data through a
// two-flop synchroniser and publishes a frame-coherent PLAYERS*BITS button
// vector (pressed = 1, player p at [p*BITS +: BITS], bit 0 shifted first).
// Optional build macro: JOY_DEBOUNCE_EN -- a player's slice only updates when
// two consecutive raw frames agree for that player.

`ifdef JOY_DEBOUNCE_EN
// Per-player debounce: accept the new raw slice only if it repeats the last one.
module joy_db_slice #(
    parameter int BITS = 12
) (
    input  logic [BITS-1:0] raw_new,
    input  logic [BITS-1:0] raw_prev,
    input  logic [BITS-1:0] held,
    output logic [BITS-1:0] next
);
    assign next = (raw_new == raw_prev) ? raw_new : held;
endmodule
`endif

module joy_serial_multi #(
    parameter int PLAYERS    = 2,
    parameter int BITS       = 12,
    parameter int CLK_DIV    = 4,
    parameter int GAP_TICKS  = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    joy_data,
    output logic                    joy_load,
    output logic                    joy_clk,
    output logic [PLAYERS*BITS-1:0] joystick,
    output logic                    frame_done,
    output logic                    valid
);
    localparam int TOTAL = PLAYERS * BITS;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    localparam logic [DIV_W-1:0] DIV_END  = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);
    localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP_TICKS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        GAP
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic             data_s1;
    logic             data_s2;
    logic             sample_bit;
    logic [IDX_W-1:0] idx;
    logic             phase;
    logic [GAP_W-1:0] gap_cnt;
    logic [TOTAL-1:0] shift_q;
    logic [TOTAL-1:0] joy_next;
    logic             capture;

    assign tick       = (div == DIV_END);
    assign sample_bit = data_s2 ^ ACTIVE_LOW;
    // Last phase-1 tick of the frame: shift_q already holds bit TOTAL-1.
    assign capture    = tick && (state == SHIFT) && phase && (idx == LAST_IDX);

    // Tick divider: one-cycle strobe every CLK_DIV clocks, phase-locked to reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
        end else if (tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Two-flop synchroniser for the asynchronous chain data line.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_s1 <= 1'b0;
            data_s2 <= 1'b0;
        end else begin
            data_s1 <= joy_data;
            data_s2 <= data_s1;
        end
    end

`ifdef JOY_DEBOUNCE_EN
    logic [TOTAL-1:0] raw_prev;

    for (genvar p = 0; p < PLAYERS; p++) begin : g_db
        joy_db_slice #(
            .BITS(BITS)
        ) u_db (
            .raw_new (shift_q[p*BITS +: BITS]),
            .raw_prev(raw_prev[p*BITS +: BITS]),
            .held    (joystick[p*BITS +: BITS]),
            .next    (joy_next[p*BITS +: BITS])
        );
    end

    // Previous raw frame, refreshed on every capture regardless of debounce outcome.
    always_ff @(posedge clk) begin
        if (reset) begin
            raw_prev <= '0;
        end else if (capture) begin
            raw_prev <= shift_q;
        end
    end
`else
    assign joy_next = shift_q;
`endif

    // Scan sequencer: load pulse, TOTAL clock pulses, capture, then idle gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            joy_load   <= 1'b1;
            joy_clk    <= 1'b0;
            joystick   <= '0;
            frame_done <= 1'b0;
            valid      <= 1'b0;
            idx        <= '0;
            phase      <= 1'b0;
            gap_cnt    <= '0;
            shift_q    <= '0;
        end else begin
            frame_done <= 1'b0;
            if (tick) begin
                unique case (state)
                    IDLE: begin
                        if (en) begin
                            state    <= LOAD;
                            joy_load <= 1'b0;
                        end else begin
                            joy_load <= 1'b1;
                            joy_clk  <= 1'b0;
                        end
                    end
                    LOAD: begin
                        joy_load <= 1'b1;
                        state    <= SHIFT;
                        idx      <= '0;
                        phase    <= 1'b0;
                    end
                    SHIFT: begin
                        if (!phase) begin
                            for (int b = 0; b < TOTAL; b++) begin
                                if (idx == IDX_W'(b)) begin
                                    shift_q[b] <= sample_bit;
                                end
                            end
                            joy_clk <= 1'b1;
                            phase   <= 1'b1;
                        end else begin
                            joy_clk <= 1'b0;
                            if (idx != LAST_IDX) begin
                                idx   <= idx + 1'b1;
                                phase <= 1'b0;
                            end else begin
                                joystick   <= joy_next;
                                frame_done <= 1'b1;
                                valid      <= 1'b1;
                                state      <= GAP;
                                gap_cnt    <= '0;
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt == GAP_END) begin
                            // Same decision as IDLE, taken on this tick.
                            if (en) begin
                                state    <= LOAD;
                                joy_load <= 1'b0;
                            end else begin
                                state    <= IDLE;
                                joy_load <= 1'b1;
                                joy_clk  <= 1'b0;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
